// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the HD44780 LCD sequencer
// Purpose : FSM state encoding, power-up init command ROM, packed o_io_lcd bit positions,
//           long-execution (clear/home) command codes and small helper functions.
// Ports   : none (package)
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_PWRUP,
      ST_SETUP,
      ST_EN,
      ST_HOLD,
      ST_WAIT,
      ST_IDLE
   } lcd_state_t;

   // Init ROM, index 0 is sent first: 8-bit/2-line, display on, clear, entry increment.
   localparam int INIT_LEN = 4;
   localparam logic [INIT_LEN-1:0][7:0] INIT_CMD = {8'h06, 8'h01, 8'h0C, 8'h38};

   // Bit positions inside the packed o_io_lcd word.
   localparam int BIT_ON   = 31;
   localparam int BIT_BLON = 30;
   localparam int BIT_EN   = 10;
   localparam int BIT_RS   = 9;
   localparam int BIT_RW   = 8;

   // Instructions that need the long (1.64 ms) execution wait.
   localparam logic [7:0] CMD_CLEAR    = 8'h01;
   localparam logic [7:0] CMD_HOME     = 8'h02;
   localparam logic [7:0] CMD_HOME_ALT = 8'h03;

   function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
      return !rs && (data == CMD_CLEAR || data == CMD_HOME || data == CMD_HOME_ALT);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/lcd_delay_cnt.sv
// rtl/lcd_delay_cnt.sv - loadable down-counter with zero flag for LCD timing
// Purpose : holds the remaining cycles of the current sequencer phase; saturates at zero.
// Ports   : i_clk      clock
//           i_reset    synchronous active-high reset, loads RST_VAL
//           i_load     load i_load_val this edge (has priority over decrement)
//           i_load_val value to load (phase length - 1)
//           o_zero     counter has reached zero
module lcd_delay_cnt #(
   parameter int           W       = 8,
   parameter logic [W-1:0] RST_VAL = '0
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   output logic         o_zero
);

   logic [W-1:0] cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         cnt <= RST_VAL;
      end else if (i_load) begin
         cnt <= i_load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign o_zero = (cnt == '0);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// rtl/lcd_seq_ctrl.sv - HD44780 character LCD init and write sequencer
// Purpose : runs the power-up init sequence, then writes one byte per valid/ready handshake,
//           generating RS/RW/EN/DATA with setup, pulse, hold and execution timing.
// Ports   : i_clk, i_reset            clock, synchronous active-high reset
//           i_req_valid/o_req_ready   byte request handshake
//           i_req_rs, i_req_data      register select and byte for the request
//           o_busy, o_init_done       status (busy = !ready; init_done sticky until reset)
//           o_lcd_on/blon/rw/rs/en    LCD pins, o_lcd_data 8-bit bus
//           o_io_lcd                  packed pin word {ON,BLON,19'b0,EN,RS,RW,DATA}
module lcd_seq_ctrl
   import lcd_pkg::*;
#(
   parameter int T_PWRUP_CYC = 750000,
   parameter int T_SETUP_CYC = 2,
   parameter int T_EN_CYC    = 25,
   parameter int T_HOLD_CYC  = 2,
   parameter int T_CMD_CYC   = 2000,
   parameter int T_CLR_CYC   = 82000
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_rs,
   input  logic [7:0]  i_req_data,
   output logic        o_busy,
   output logic        o_init_done,
   output logic        o_lcd_on,
   output logic        o_lcd_blon,
   output logic        o_lcd_rw,
   output logic        o_lcd_rs,
   output logic        o_lcd_en,
   output logic [7:0]  o_lcd_data,
   output logic [31:0] o_io_lcd
);

   localparam int T_MAX = max_int(max_int(max_int(T_PWRUP_CYC, T_SETUP_CYC),
                                          max_int(T_EN_CYC, T_HOLD_CYC)),
                                  max_int(T_CMD_CYC, T_CLR_CYC));
   localparam int CNT_W = $clog2(T_MAX) + 1;

   lcd_state_t state, state_n;
   logic       en_q, en_n;
   logic       rs_q, rs_n;
   logic [7:0] data_q, data_n;
   logic       ready_q, ready_n;
   logic       done_q, done_n;
   logic [1:0] idx_q, idx_n;
   logic [1:0] idx_inc;

   logic             cnt_load;
   logic [CNT_W-1:0] cnt_val;
   logic             cnt_zero;

   lcd_delay_cnt #(
      .W       (CNT_W),
      .RST_VAL (CNT_W'(T_PWRUP_CYC - 1))
   ) u_delay (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_load     (cnt_load),
      .i_load_val (cnt_val),
      .o_zero     (cnt_zero)
   );

   assign idx_inc = idx_q + 2'd1;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state   <= ST_PWRUP;
         en_q    <= 1'b0;
         rs_q    <= 1'b0;
         data_q  <= 8'h00;
         ready_q <= 1'b0;
         done_q  <= 1'b0;
         idx_q   <= 2'd0;
      end else begin
         state   <= state_n;
         en_q    <= en_n;
         rs_q    <= rs_n;
         data_q  <= data_n;
         ready_q <= ready_n;
         done_q  <= done_n;
         idx_q   <= idx_n;
      end
   end

   // Every phase change reloads the shared counter with the next phase length - 1,
   // so a phase of T cycles ends on the T-th edge after entry.
   always_comb begin
      state_n  = state;
      en_n     = en_q;
      rs_n     = rs_q;
      data_n   = data_q;
      ready_n  = ready_q;
      done_n   = done_q;
      idx_n    = idx_q;
      cnt_load = 1'b0;
      cnt_val  = '0;

      case (state)
         ST_PWRUP: begin
            if (cnt_zero) begin
               state_n  = ST_SETUP;
               rs_n     = 1'b0;
               data_n   = INIT_CMD[0];
               idx_n    = 2'd0;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(T_SETUP_CYC - 1);
            end
         end
         ST_IDLE: begin
            if (i_req_valid && ready_q) begin
               state_n  = ST_SETUP;
               rs_n     = i_req_rs;
               data_n   = i_req_data;
               ready_n  = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(T_SETUP_CYC - 1);
            end
         end
         ST_SETUP: begin
            if (cnt_zero) begin
               state_n  = ST_EN;
               en_n     = 1'b1;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(T_EN_CYC - 1);
            end
         end
         ST_EN: begin
            if (cnt_zero) begin
               state_n  = ST_HOLD;
               en_n     = 1'b0;
               cnt_load = 1'b1;
               cnt_val  = CNT_W'(T_HOLD_CYC - 1);
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_n  = ST_WAIT;
               cnt_load = 1'b1;
               cnt_val  = is_long_cmd(rs_q, data_q) ? CNT_W'(T_CLR_CYC - 1)
                                                    : CNT_W'(T_CMD_CYC - 1);
            end
         end
         ST_WAIT: begin
            if (cnt_zero) begin
               // Before init completes, WAIT either chains the next ROM byte or finishes init.
               if (!done_q && idx_q != 2'(INIT_LEN - 1)) begin
                  state_n  = ST_SETUP;
                  idx_n    = idx_inc;
                  rs_n     = 1'b0;
                  data_n   = INIT_CMD[idx_inc];
                  cnt_load = 1'b1;
                  cnt_val  = CNT_W'(T_SETUP_CYC - 1);
               end else begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
                  ready_n = 1'b1;
               end
            end
         end
         default: begin
            state_n = ST_PWRUP;
            en_n    = 1'b0;
            ready_n = 1'b0;
         end
      endcase
   end

   assign o_req_ready = ready_q;
   assign o_busy      = ~ready_q;
   assign o_init_done = done_q;
   assign o_lcd_on    = 1'b1;
   assign o_lcd_blon  = 1'b1;
   assign o_lcd_rw    = 1'b0;
   assign o_lcd_rs    = rs_q;
   assign o_lcd_en    = en_q;
   assign o_lcd_data  = data_q;

   always_comb begin
      o_io_lcd           = '0;
      o_io_lcd[BIT_ON]   = 1'b1;
      o_io_lcd[BIT_BLON] = 1'b1;
      o_io_lcd[BIT_EN]   = en_q;
      o_io_lcd[BIT_RS]   = rs_q;
      o_io_lcd[BIT_RW]   = 1'b0;
      o_io_lcd[7:0]      = data_q;
   end

endmodule
